// File: rtl/sum_feeder_if.sv
// Handshake and result bundle between a host/responder and sum_feeder.
interface sum_feeder_if;
   logic       clear;
   logic       load_valid;
   logic [7:0] load_data;
   logic       load_ready;
   logic       start;
   logic       busy;
   logic       go_l;
   logic [7:0] inA;
   logic       done;
   logic [7:0] sum;
   logic [7:0] exp_sum;
   logic       match;
   logic       mismatch;
   logic       timeout;

   // host / responder side
   modport master (
      output clear, load_valid, load_data, start, done, sum,
      input  load_ready, busy, go_l, inA, exp_sum, match, mismatch, timeout
   );

   // feeder side
   modport slave (
      input  clear, load_valid, load_data, start, done, sum,
      output load_ready, busy, go_l, inA, exp_sum, match, mismatch, timeout
   );
endinterface

// File: rtl/sum_feeder.sv
// Operand buffer that streams its contents to a summing responder after a
// go pulse, terminates the stream with 0, and checks the returned sum.
module sum_feeder #(
   parameter int DEPTH   = 8,
   parameter int TIMEOUT = 16
) (
   input  logic         clock,
   input  logic         reset,
   sum_feeder_if.slave  bus
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] GO   = 3'd1;
   localparam logic [2:0] SEND = 3'd2;
   localparam logic [2:0] TERM = 3'd3;
   localparam logic [2:0] WAIT = 3'd4;

   logic [2:0]    state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] idx_q, idx_d;
   logic [TW-1:0] wcnt_q, wcnt_d;
   logic [7:0]    exp_sum_q, exp_sum_d;
   logic          match_q, match_d;
   logic          mismatch_q, mismatch_d;
   logic          timeout_q, timeout_d;
   logic [7:0]    mem_q [DEPTH];

   logic          load_ready;
   logic          load_xfer;
   logic          start_acc;
   logic          mem_we;

   assign load_ready = (state_q == IDLE) && (count_q < CW'(DEPTH)) && !bus.clear;
   assign load_xfer  = load_ready && bus.load_valid;
   // a load in the same cycle wins over start
   assign start_acc  = (state_q == IDLE) && bus.start && !bus.clear && !load_xfer;

   // next-state, buffer bookkeeping and result evaluation
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      idx_d      = idx_q;
      wcnt_d     = wcnt_q;
      exp_sum_d  = exp_sum_q;
      match_d    = match_q;
      mismatch_d = mismatch_q;
      timeout_d  = timeout_q;
      mem_we     = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.clear) begin
               count_d = '0;
            end else if (load_xfer && (bus.load_data != 8'd0)) begin
               // zero is the terminator: accepted but never stored
               mem_we  = 1'b1;
               count_d = count_q + CW'(1);
            end
            if (start_acc) begin
               match_d    = 1'b0;
               mismatch_d = 1'b0;
               timeout_d  = 1'b0;
               exp_sum_d  = 8'd0;
               idx_d      = '0;
               state_d    = GO;
            end
         end
         GO: begin
            idx_d   = '0;
            state_d = (count_q == '0) ? TERM : SEND;
         end
         SEND: begin
            exp_sum_d = exp_sum_q + mem_q[idx_q[IW-1:0]];
            if (idx_q == count_q - CW'(1)) state_d = TERM;
            else                           idx_d   = idx_q + CW'(1);
         end
         TERM: begin
            wcnt_d  = '0;
            state_d = WAIT;
         end
         WAIT: begin
            if (bus.done) begin
               match_d    = (bus.sum == exp_sum_q);
               mismatch_d = (bus.sum != exp_sum_q);
               state_d    = IDLE;
            end else if (wcnt_q == TW'(TIMEOUT - 1)) begin
               timeout_d = 1'b1;
               state_d   = IDLE;
            end else begin
               wcnt_d = wcnt_q + TW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // control and result registers, reset has top priority
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         count_q    <= '0;
         idx_q      <= '0;
         wcnt_q     <= '0;
         exp_sum_q  <= 8'd0;
         match_q    <= 1'b0;
         mismatch_q <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         idx_q      <= idx_d;
         wcnt_q     <= wcnt_d;
         exp_sum_q  <= exp_sum_d;
         match_q    <= match_d;
         mismatch_q <= mismatch_d;
         timeout_q  <= timeout_d;
      end
   end

   // operand storage, contents kept across transactions for replay
   always_ff @(posedge clock) begin
      if (mem_we && !reset) mem_q[count_q[IW-1:0]] <= bus.load_data;
   end

   // stream output: operands only in SEND, zero elsewhere
   always_comb begin
      bus.inA = 8'd0;
      if (state_q == SEND) bus.inA = mem_q[idx_q[IW-1:0]];
   end

   assign bus.load_ready = load_ready;
   assign bus.busy       = (state_q != IDLE);
   assign bus.go_l       = (state_q != GO);
   assign bus.exp_sum    = exp_sum_q;
   assign bus.match      = match_q;
   assign bus.mismatch   = mismatch_q;
   assign bus.timeout    = timeout_q;

endmodule

// File: doc/sum_feeder.md
SUM_FEEDER -- requirements
Module: sum_feeder

Interface
REQ-001 Parameter DEPTH, default 8: number of 8-bit operand entries the buffer SHALL hold.
REQ-002 Parameter TIMEOUT, default 16: maximum cycles the block SHALL wait for done after the terminator.
REQ-003 Port clock, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port clear, input, 1: synchronous flush of the operand buffer.
REQ-006 Port load_valid, input, 1: host offers load_data this cycle.
REQ-007 Port load_data, input, 8: operand to append to the buffer.
REQ-008 Port load_ready, output, 1: the block accepts load_data this cycle.
REQ-009 Port start, input, 1: request to run one summing transaction.
REQ-010 Port busy, output, 1: a transaction is in progress.
REQ-011 Port go_l, output, 1: active-low go pulse to the summing responder.
REQ-012 Port inA, output, 8: operand stream to the responder.
REQ-013 Port done, input, 1: responder result-valid strobe.
REQ-014 Port sum, input, 8: responder result, sampled only while done=1.
REQ-015 Port exp_sum, output, 8: locally computed expected sum.
REQ-016 Ports match, mismatch, timeout, outputs, 1 each: sticky result flags.

Function
REQ-017 States SHALL be IDLE, GO, SEND, TERM, WAIT.
REQ-018 Load: a transfer SHALL occur when load_valid and load_ready are both 1; load_ready SHALL be 1 only in IDLE with count<DEPTH and clear=0.
REQ-019 A load_data value of 0 SHALL be consumed but not stored, because 0 is the stream terminator.
REQ-020 When clear=1 in IDLE, count SHALL become 0; clear outside IDLE SHALL be ignored.
REQ-021 start SHALL be accepted only in IDLE with clear=0 and no load transfer in the same cycle; in all other cases it SHALL be ignored.
REQ-022 Acceptance at edge t SHALL clear match, mismatch, timeout, and exp_sum, and SHALL enter GO.
REQ-023 GO SHALL last exactly one cycle with go_l=0 and inA=0; in every other state go_l SHALL be 1.
REQ-024 SEND SHALL present buffer entries in load order, one per cycle, for exactly count cycles.
REQ-025 In SEND, exp_sum SHALL accumulate each presented entry modulo 256, with no carry out.
REQ-026 With count=0, GO SHALL go directly to TERM, and exp_sum SHALL remain 0.
REQ-027 TERM SHALL last one cycle with inA=0; inA SHALL be 0 in IDLE, GO, TERM, and WAIT.
REQ-028 WAIT timing:
- On the first cycle with done=1, the block SHALL set match=1 if sum==exp_sum, else mismatch=1, and return to IDLE.
- After TIMEOUT WAIT cycles with done=0, the block SHALL set timeout=1 and return to IDLE.
REQ-029 done asserted outside WAIT SHALL be ignored.
REQ-030 busy SHALL be 1 in GO, SEND, TERM, and WAIT, and 0 in IDLE.
REQ-031 The buffer SHALL be retained after a transaction, so a new start replays the same operands.
REQ-032 Total latency: with N entries and start accepted at edge t, go_l SHALL be low in cycle t+1, operands in cycles t+2..t+1+N, and the terminator in cycle t+2+N.
REQ-033 exp_sum, match, mismatch, and timeout SHALL hold their values until the next accepted start or reset.

Reset
REQ-034 reset SHALL take priority over every other input, including mid-transaction.
REQ-035 reset SHALL force:
- state IDLE and count=0;
- go_l=1, inA=0, busy=0;
- exp_sum=0;
- match=0, mismatch=0, timeout=0;
- load_ready=1 in the following cycle.

Verification
REQ-036 Basic match: load 4,4, start; responder returns done=1, sum=8 in WAIT -> go_l low for 1 cycle, inA sequence 0,4,4,0, exp_sum=8, match=1.
REQ-037 Mismatch: load 3,3,3, start; responder returns sum=10 -> exp_sum=9, mismatch=1, match=0.
REQ-038 Wrap and zero drop: load 200,0,100, start -> stream 200,100,0, exp_sum=44; a returned sum=44 gives match=1.
REQ-039 Full buffer: 8 loads succeed -> load_ready=0 on the 9th offer; clear=1 -> count=0; start -> stream is terminator only, exp_sum=0.
REQ-040 Timeout and replay: start with done held 0 -> timeout=1 exactly 16 WAIT cycles after TERM, busy=0; a second start replays the identical stream.
REQ-041 Reset mid-SEND: assert reset during the 2nd operand -> next cycle IDLE, go_l=1, inA=0, all flags 0, count=0.
